hps_image_loader: RTL and testbench

- Avalon-MM write slave between the HPS bridge and the ImgRam write port.
- Accepts 32-bit words, each packing 4 consecutive 8-bit pixels (lane 0 = lowest address), buffers them in a small FIFO, and serializes them into one-byte ImgRam writes.
- Provides the image-load busy and done status that the processing FSM uses in place of the raw HPS write strobe.

---
 rtl/img_pkg.sv | 27 ++
 rtl/loader_word_fifo.sv | 60 ++++++
 rtl/hps_image_loader.sv | 155 +++++++++++++++
 tb/tb_hps_image_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// img_pkg
// Shared image geometry, ImgRam/Avalon address widths, the serializer
// state encoding, and a lane-select helper for the HPS image loader.
package img_pkg;

  localparam int IMG_W      = 160;
  localparam int IMG_H      = 120;
  localparam int IMG_PIXELS = IMG_W * IMG_H;
  localparam int RAM_AW     = 15;
  localparam int WORD_AW    = 13;

  typedef enum logic {
    IDLE,
    EMIT
  } loader_state_t;

  // Index of the lowest set bit of a 4-lane byteenable mask (0 when empty).
  function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/loader_word_fifo.sv
// loader_word_fifo
// Small synchronous FIFO holding packed Avalon write words ahead of the
// byte serializer.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   push, push_data     write side (push is ignored while full)
//   pop, pop_data       read side; pop_data shows the head (first-word fall-through)
//   full, empty, count  occupancy status, all from registered state
module loader_word_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not reset: only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hps_image_loader.sv
// hps_image_loader
// Avalon-MM write slave that takes 32-bit words of four packed pixels from
// the HPS bridge, queues them, and replays them as one-byte ImgRam writes.
// Also produces the busy / load_done status used by the processing FSM.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   avs_*                      Avalon-MM write slave (no reads)
//   clear                      synchronous pulse starting a new image load
//   ram_wraddress/data/wren    registered ImgRam write port
//   busy, load_done            loader activity and sticky completion flag
//   pixel_count, addr_error    bytes written since clear, sticky range fault
module hps_image_loader #(
  parameter int IMG_PIXELS = img_pkg::IMG_PIXELS,
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_AW     = img_pkg::RAM_AW,
  parameter int WORD_AW    = img_pkg::WORD_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_AW-1:0] avs_address,
  input  logic               avs_chipselect,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic [3:0]         avs_byteenable,
  output logic               avs_waitrequest,
  input  logic               clear,
  output logic [RAM_AW-1:0]  ram_wraddress,
  output logic [7:0]         ram_data,
  output logic               ram_wren,
  output logic               busy,
  output logic               load_done,
  output logic [RAM_AW-1:0]  pixel_count,
  output logic               addr_error
);

  import img_pkg::*;

  localparam int FW = WORD_AW + 32 + 4;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WORD_AW-1:0] WORD_LIMIT = WORD_AW'(IMG_PIXELS / 4);
  localparam logic [RAM_AW-1:0]  PIX_MAX    = RAM_AW'(IMG_PIXELS);

  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      fifo_count_next;
  logic [FW-1:0]      head;
  logic [WORD_AW-1:0] head_addr;
  logic [31:0]        head_data;
  logic [3:0]         head_be;
  logic               head_ok;

  loader_state_t      state;
  logic [WORD_AW-1:0] w_addr;
  logic [31:0]        w_data;
  logic [3:0]         w_mask;
  logic [1:0]         lane;
  logic [3:0]         rest_mask;
  logic               last_lane;
  logic               emit;
  logic               goes_emit;

  assign avs_waitrequest = fifo_full;
  assign push = avs_chipselect && avs_write && !fifo_full;
  assign {head_addr, head_data, head_be} = head;

  loader_word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({avs_address, avs_writedata, avs_byteenable}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Serializer control: a new word is popped when idle, or on the last
  // enabled lane so full words stream back to back without a bubble.
  // Words with no enabled lanes or an out-of-range address are popped and
  // dropped without entering EMIT.
  always_comb begin
    emit      = (state == EMIT);
    rest_mask = w_mask & ~(4'b0001 << lane);
    last_lane = (rest_mask == 4'b0000);
    pop       = !fifo_empty && (!emit || last_lane);
    head_ok   = (head_be != 4'b0000) && (head_addr < WORD_LIMIT);
    goes_emit = (emit && !last_lane) || (pop && head_ok);
    case ({push, pop})
      2'b10:   fifo_count_next = fifo_count + 1'b1;
      2'b01:   fifo_count_next = fifo_count - 1'b1;
      default: fifo_count_next = fifo_count;
    endcase
  end

  // Serializer FSM with registered RAM port and status. busy is computed
  // from next-cycle occupancy/state so it is already high the cycle after
  // the accepting edge. Setting events win over clear so an in-flight byte
  // counts toward the new load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      w_addr        <= '0;
      w_data        <= '0;
      w_mask        <= '0;
      lane          <= '0;
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_data      <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      pixel_count   <= '0;
      addr_error    <= 1'b0;
    end else begin
      state <= goes_emit ? EMIT : IDLE;
      busy  <= (fifo_count_next != '0) || goes_emit;

      ram_wren <= emit;
      if (emit) begin
        ram_wraddress <= RAM_AW'({w_addr, lane});
        ram_data      <= w_data[{lane, 3'b000} +: 8];
      end

      if (emit && !last_lane) begin
        w_mask <= rest_mask;
        lane   <= lowest_lane(rest_mask);
      end else if (pop && head_ok) begin
        w_addr <= head_addr;
        w_data <= head_data;
        w_mask <= head_be;
        lane   <= lowest_lane(head_be);
      end

      if (clear) begin
        pixel_count <= emit ? RAM_AW'(1) : '0;
        load_done   <= 1'b0;
      end else if (emit && pixel_count != PIX_MAX) begin
        pixel_count <= pixel_count + 1'b1;
        if (pixel_count == PIX_MAX - 1'b1) load_done <= 1'b1;
      end

      if (pop && head_be != 4'b0000 && head_addr >= WORD_LIMIT)
        addr_error <= 1'b1;
      else if (clear)
        addr_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hps_image_loader.sv
// tb_hps_image_loader
// Scoreboard bench: each accepted Avalon word pushes its expected ImgRam
// byte writes into a queue; a monitor pops and compares on every ram_wren.
module tb_hps_image_loader;
  import img_pkg::*;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] avs_address;
  logic        avs_chipselect;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic        clear;
  logic [14:0] ram_wraddress;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        busy;
  logic        load_done;
  logic [14:0] pixel_count;
  logic        addr_error;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wren_count = 0;
  int   run_len = 0;
  int   max_run = 0;
  bit   saw_wait = 0;

  always #5 clk = ~clk;

  hps_image_loader dut (
    .clk             (clk),
    .reset           (reset),
    .avs_address     (avs_address),
    .avs_chipselect  (avs_chipselect),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_byteenable  (avs_byteenable),
    .avs_waitrequest (avs_waitrequest),
    .clear           (clear),
    .ram_wraddress   (ram_wraddress),
    .ram_data        (ram_data),
    .ram_wren        (ram_wren),
    .busy            (busy),
    .load_done       (load_done),
    .pixel_count     (pixel_count),
    .addr_error      (addr_error)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one write, hold it until accepted, then queue its expected bytes.
  task automatic applyStimulus(input logic [12:0] addr, input logic [31:0] data,
                               input logic [3:0] be);
    int  waited;
    bit  accepted;
    bit  done;
    @(negedge clk);
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    waited   = 0;
    accepted = 0;
    done     = 0;
    while (!done) begin
      if (!avs_waitrequest) begin
        @(posedge clk);
        accepted = 1;
        done     = 1;
      end else begin
        saw_wait = 1;
        @(negedge clk);
        waited++;
        if (waited > 1000) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: got waitrequest=1 expected accept within 1000 cycles");
          done = 1;
        end
      end
    end
    if (accepted && addr < 13'(IMG_PIXELS / 4)) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) exp_q.push_back({addr, 2'(l), data[l*8 +: 8]});
      end
    end
  endtask

  task automatic idleBus();
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || ram_wren) && n < 500);
    if (busy || ram_wren) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_idle_timeout: got busy=%0b wren=%0b expected 0 0", name, busy, ram_wren);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_waitrequest"}, 32'(avs_waitrequest), 0);
    checkOutput({tag, "_wren"},        32'(ram_wren), 0);
    checkOutput({tag, "_wraddress"},   32'(ram_wraddress), 0);
    checkOutput({tag, "_data"},        32'(ram_data), 0);
    checkOutput({tag, "_busy"},        32'(busy), 0);
    checkOutput({tag, "_load_done"},   32'(load_done), 0);
    checkOutput({tag, "_pixel_count"}, 32'(pixel_count), 0);
    checkOutput({tag, "_addr_error"},  32'(addr_error), 0);
  endtask

  // Monitor: every ImgRam write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ram_wren) begin
      wren_count++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                 ram_wraddress, ram_data);
      end else begin
        e = exp_q.pop_front();
        if (ram_wraddress !== e.addr || ram_data !== e.data) begin
          errors++;
          $display("[TB] FAIL ram_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                   ram_wraddress, ram_data, e.addr, e.data);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    int base;
    int n;
    reset          = 1'b1;
    avs_address    = '0;
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    clear          = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);
    checkAllZero("post_reset");

    // Single full word, latency and byte order.
    applyStimulus(13'd0, 32'h44332211, 4'hF);
    #1 checkOutput("t1_busy_after_accept", 32'(busy), 1);
    idleBus();
    @(posedge clk);
    #1 checkOutput("t1_wren_edge1", 32'(ram_wren), 0);
    @(posedge clk);
    #1 checkOutput("t1_wren_edge2", 32'(ram_wren), 1);
    checkOutput("t1_addr_edge2", 32'(ram_wraddress), 0);
    checkOutput("t1_data_edge2", 32'(ram_data), 32'h11);
    waitIdle("t1");
    checkOutput("t1_pixel_count", 32'(pixel_count), 4);
    checkOutput("t1_busy", 32'(busy), 0);
    checkOutput("t1_load_done", 32'(load_done), 0);

    // Six back-to-back words: backpressure and gapless streaming.
    saw_wait = 0;
    max_run  = 0;
    for (int i = 0; i < 6; i++)
      applyStimulus(13'(10 + i), 32'hA3A2A1A0 + 32'(i) * 32'h10101010, 4'hF);
    idleBus();
    waitIdle("t2");
    checkOutput("t2_saw_waitrequest", 32'(saw_wait), 1);
    checkOutput("t2_no_gap_run", 32'(max_run), 24);
    checkOutput("t2_pixel_count", 32'(pixel_count), 28);

    // Sparse byteenable, then an empty one.
    base = wren_count;
    applyStimulus(13'd2, 32'hDDCCBBAA, 4'b1010);
    idleBus();
    waitIdle("t3a");
    checkOutput("t3_sparse_writes", 32'(wren_count - base), 2);
    base = wren_count;
    applyStimulus(13'd3, 32'h12345678, 4'b0000);
    idleBus();
    waitIdle("t3b");
    checkOutput("t3_be0_writes", 32'(wren_count - base), 0);
    checkOutput("t3_be0_busy", 32'(busy), 0);
    checkOutput("t3_pixel_count", 32'(pixel_count), 30);

    // Out-of-range word is dropped and flagged.
    pulseClear();
    checkOutput("t4_clear_count", 32'(pixel_count), 0);
    base = wren_count;
    applyStimulus(13'd4800, 32'hFFEEDDCC, 4'hF);
    idleBus();
    waitIdle("t4a");
    checkOutput("t4_range_writes", 32'(wren_count - base), 0);
    checkOutput("t4_addr_error", 32'(addr_error), 1);
    checkOutput("t4_count_unchanged", 32'(pixel_count), 0);
    applyStimulus(13'd5, 32'h04030201, 4'hF);
    idleBus();
    waitIdle("t4b");
    checkOutput("t4_after_count", 32'(pixel_count), 4);
    checkOutput("t4_error_sticky", 32'(addr_error), 1);

    // Full image stream, load_done timing and saturation.
    pulseClear();
    checkOutput("t5_clear_error", 32'(addr_error), 0);
    for (int i = 0; i < 4799; i++)
      applyStimulus(13'(i), {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)}, 4'hF);
    idleBus();
    waitIdle("t5a");
    checkOutput("t5_count_19196", 32'(pixel_count), 19196);
    checkOutput("t5_done_early", 32'(load_done), 0);
    applyStimulus(13'd4799, 32'h5A5B5C5D, 4'hF);
    idleBus();
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      if (ram_wren) begin
        n++;
        if (n == 3) begin
          checkOutput("t5_count_19199", 32'(pixel_count), 19199);
          checkOutput("t5_done_before_last", 32'(load_done), 0);
        end
        if (n == 4) begin
          checkOutput("t5_count_19200", 32'(pixel_count), 19200);
          checkOutput("t5_done_on_last", 32'(load_done), 1);
        end
      end
    end
    checkOutput("t5_last_word_writes", 32'(n), 4);
    waitIdle("t5b");
    applyStimulus(13'd100, 32'h01020304, 4'hF);
    idleBus();
    waitIdle("t5c");
    checkOutput("t5_count_saturated", 32'(pixel_count), 19200);
    checkOutput("t5_done_sticky", 32'(load_done), 1);
    pulseClear();
    checkOutput("t5_clear_done", 32'(load_done), 0);
    checkOutput("t5_clear_count", 32'(pixel_count), 0);

    // Reset in the middle of a word.
    applyStimulus(13'd7, 32'h87654321, 4'hF);
    idleBus();
    n = 0;
    while (!ram_wren && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_wren_seen", 32'(ram_wren), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 checkAllZero("t6_mid_reset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(13'd8, 32'h0D0C0B0A, 4'hF);
    idleBus();
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("t6_first_addr", 32'(ram_wraddress), 32);
    checkOutput("t6_first_data", 32'(ram_data), 32'h0A);
    waitIdle("t6");
    checkOutput("t6_pixel_count", 32'(pixel_count), 4);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
